// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
// Contents: the responder FSM state type, the default data-segment base address,
// and the wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
  localparam int unsigned DMEM_CNT_W     = 4;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the datapath (master) and the data memory (slave).
//   req_*  : valid/ready request channel carrying write flag, byte address,
//            store data and byte enables
//   resp_* : valid/ready response channel carrying load data and error flag
interface data_memory_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_memory_responder_word_array.sv
// DEPTH x 32-bit synchronous RAM with per-byte-lane write enables.
//   clk   : rising-edge clock
//   en    : access enable; read and write happen only when set
//   we    : byte-lane write enables (bit i writes bits 8i+7:8i)
//   addr  : word index
//   wdata : store data
//   rdata : registered read data, returns the word as it was before a same-edge write
// No reset: contents and rdata are undefined until written/read.
module dmem_word_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-port memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES clocks, commits the access to the word RAM and holds the
// response until the initiator takes it. Misaligned or out-of-range
// addresses give an error response and never touch the RAM.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : request/response channel (slave side)
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned           AW        = $clog2(DEPTH);
  localparam logic [32:0]           END_ADDR  = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_CYCLES);

  if (END_ADDR[32] || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES > 15 ||
      (BASE_ADDR & 32'(4 * DEPTH - 1)) != '0) begin : g_cfg_check
    $error("data_memory_responder: illegal DEPTH/BASE_ADDR/WAIT_CYCLES configuration");
  end

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic                  accept, commit;

  logic                  lat_write;
  logic [31:0]           lat_addr, lat_wdata;
  logic [3:0]            lat_be;

  logic                  use_live;
  logic                  c_write;
  logic [31:0]           c_addr, c_wdata;
  logic [3:0]            c_be;
  logic                  addr_err;
  logic [AW-1:0]         word_idx;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  logic                  resp_valid_q, resp_err_q, resp_load_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    commit        = 1'b0;
    bus.req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == DMEM_CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      cnt_q     <= WAIT_INIT;
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // With zero wait states the commit happens on the accept edge itself,
  // so the request is taken straight from the bus instead of the latches.
  always_comb begin
    use_live = (state_q == IDLE);
    c_write  = use_live ? bus.req_write : lat_write;
    c_addr   = use_live ? bus.req_addr  : lat_addr;
    c_wdata  = use_live ? bus.req_wdata : lat_wdata;
    c_be     = use_live ? bus.req_be    : lat_be;
  end

  // BASE_ADDR is aligned to the RAM size, so for any in-range address the
  // word index (addr - BASE_ADDR)/4 is simply the low address bits.
  always_comb begin
    addr_err = (c_addr[1:0] != 2'b00) ||
               ({1'b0, c_addr} <  {1'b0, BASE_ADDR}) ||
               ({1'b0, c_addr} >= END_ADDR);
    word_idx = c_addr[AW+1:2];
    ram_en   = commit && !addr_err;
    ram_we   = c_write ? c_be : '0;
  end

  dmem_word_array #(
    .DEPTH (DEPTH)
  ) u_word_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
    end else if (commit) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= addr_err;
      resp_load_q  <= !c_write && !addr_err;
    end else if (state_q == RESP && bus.resp_ready) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
    end
  end

  // RAM read data is only loaded on a commit, so it stays stable through RESP;
  // the gate forces zero for stores, errors, idle and reset.
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_load_q ? ram_rdata : '0;

endmodule
